// File: rtl/chord_mixer.sv
// rtl/chord_mixer.sv - mixes three per-voice sample streams into one saturated 16-bit codec sample
module chord_mixer #(
  parameter int TIMEOUT = 64,
  parameter int SHIFT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        generate_next_sample,
  input  logic [2:0]  voice_active,
  input  logic [47:0] sample_in,
  input  logic [2:0]  sample_valid,
  output logic [15:0] sample_out,
  output logic        new_sample_ready,
  output logic [2:0]  missed,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, SUM} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer;
  logic [2:0]     mask;
  logic [2:0]     got;
  logic [2:0]     cap;
  logic [2:0]     got_nxt;
  logic           start;
  logic [15:0]    held [3];

  logic signed [17:0] sum_full;
  logic signed [17:0] sum_shr;
  logic [15:0]        sum_sat;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cap       = mask & sample_valid;
    got_nxt   = got | cap;
    case (state)
      IDLE: begin
        if (generate_next_sample) begin
          start     = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (((got_nxt & mask) == mask) || (timer == TW'(TIMEOUT - 1)))
          state_nxt = SUM;
      end
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held samples are zeroed at request time, so missing voices add nothing.
  always_comb begin
    sum_full = {{2{held[0][15]}}, held[0]}
             + {{2{held[1][15]}}, held[1]}
             + {{2{held[2][15]}}, held[2]};
    sum_shr  = sum_full >>> SHIFT;
    if (sum_shr > 18'sd32767)
      sum_sat = 16'h7fff;
    else if (sum_shr < -18'sd32768)
      sum_sat = 16'h8000;
    else
      sum_sat = sum_shr[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask             <= 3'b000;
      got              <= 3'b000;
      timer            <= '0;
      sample_out       <= 16'h0000;
      new_sample_ready <= 1'b0;
      missed           <= 3'b000;
      overrun          <= 1'b0;
      for (int i = 0; i < 3; i++)
        held[i] <= 16'h0000;
    end else begin
      new_sample_ready <= 1'b0;
      if (generate_next_sample && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            mask  <= voice_active;
            got   <= 3'b000;
            timer <= '0;
            for (int i = 0; i < 3; i++)
              held[i] <= 16'h0000;
          end
        end
        COLLECT: begin
          for (int i = 0; i < 3; i++)
            if (cap[i])
              held[i] <= sample_in[16*i +: 16];
          got   <= got_nxt;
          timer <= timer + 1'b1;
        end
        SUM: begin
          sample_out       <= sum_sat;
          missed           <= mask & ~got;
          new_sample_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chord_mixer.sv
// tb/tb_chord_mixer.sv - directed-vector bench for chord_mixer
module tb_chord_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        gen;
  logic [2:0]  act;
  logic [2:0]  vld;
  logic [15:0] p1, p2, p3;
  logic [47:0] sin;

  logic [15:0] so0, so1, so2;
  logic        nsr0, nsr1, nsr2;
  logic [2:0]  mis0, mis1, mis2;
  logic        ovr0, ovr1, ovr2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int base;

  always #5 clk = ~clk;
  assign sin = {p1, p2, p3};

  chord_mixer #(.TIMEOUT(8), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .generate_next_sample(gen), .voice_active(act),
    .sample_in(sin), .sample_valid(vld), .sample_out(so0), .new_sample_ready(nsr0),
    .missed(mis0), .overrun(ovr0));
  chord_mixer #(.TIMEOUT(8), .SHIFT(1)) dut1 (
    .clk(clk), .reset(reset), .generate_next_sample(gen), .voice_active(act),
    .sample_in(sin), .sample_valid(vld), .sample_out(so1), .new_sample_ready(nsr1),
    .missed(mis1), .overrun(ovr1));
  chord_mixer #(.TIMEOUT(8), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .generate_next_sample(gen), .voice_active(act),
    .sample_in(sin), .sample_valid(vld), .sample_out(so2), .new_sample_ready(nsr2),
    .missed(mis2), .overrun(ovr2));

  always @(negedge clk) begin
    if (nsr0) begin
      pulses++;
      last_pulse = cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [2:0] a, input logic [2:0] v,
                       input int s1, input int s2, input int s3);
    gen = g;
    act = a;
    vld = v;
    p1  = s1[15:0];
    p2  = s2[15:0];
    p3  = s3[15:0];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, act, 3'b000, 0, 0, 0);
  endtask

  task automatic run_basic(input string tag);
    cyc  = 0;
    base = pulses;
    drive(1'b1, 3'b111, 3'b000, 0, 0, 0);
    // voice_active dropping mid-collection must not shrink the latched mask
    drive(1'b0, 3'b000, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b000, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b000, 3'b100, 1000, 0, 0);
    drive(1'b0, 3'b000, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b000, 3'b011, 0, 2000, -500);
    idle(3);
    chk({tag, "_pulses"}, pulses - base, 1);
    chk({tag, "_pulse_cyc"}, last_pulse, 7);
    chk({tag, "_sum"}, int'($signed(so0)), 2500);
    chk({tag, "_sum_shift1"}, int'($signed(so1)), 1250);
    chk({tag, "_sum_shift2"}, int'($signed(so2)), 625);
    chk({tag, "_missed"}, int'(mis0), 0);
  endtask

  initial begin
    reset = 1'b1;
    gen = 1'b0; act = 3'b000; vld = 3'b000;
    p1 = 16'h0; p2 = 16'h0; p3 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample_out", int'(so0), 0);
    chk("rst_ready", int'(nsr0), 0);
    chk("rst_missed", int'(mis0), 0);
    chk("rst_overrun", int'(ovr0), 0);
    reset = 1'b0;
    idle(2);

    run_basic("basic");

    // Request-cycle valids are ignored; unmasked player2 is ignored.
    cyc = 0; base = pulses;
    drive(1'b1, 3'b101, 3'b111, 5555, 5555, 5555);
    drive(1'b0, 3'b101, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b101, 3'b111, 700, 9999, -200);
    idle(3);
    chk("mask101_pulses", pulses - base, 1);
    chk("mask101_pulse_cyc", last_pulse, 4);
    chk("mask101_sum", int'($signed(so0)), 500);
    chk("mask101_missed", int'(mis0), 0);

    cyc = 0; base = pulses;
    drive(1'b1, 3'b111, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b111, 3'b111, 30000, 30000, 30000);
    idle(3);
    chk("satpos_pulse_cyc", last_pulse, 3);
    chk("satpos_shift0", int'($signed(so0)), 32767);
    chk("satpos_shift1", int'($signed(so1)), 32767);
    chk("satpos_shift2", int'($signed(so2)), 22500);

    cyc = 0; base = pulses;
    drive(1'b1, 3'b111, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b111, 3'b111, -30000, -30000, -30000);
    idle(3);
    chk("satneg_shift0", int'($signed(so0)), -32768);
    chk("satneg_shift1", int'($signed(so1)), -32768);
    chk("satneg_shift2", int'($signed(so2)), -22500);

    cyc = 0; base = pulses;
    drive(1'b1, 3'b111, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b111, 3'b100, 100, 0, 0);
    drive(1'b0, 3'b111, 3'b010, 0, 200, 0);
    idle(10);
    chk("timeout_pulses", pulses - base, 1);
    chk("timeout_pulse_cyc", last_pulse, 10);
    chk("timeout_sum", int'($signed(so0)), 300);
    chk("timeout_missed", int'(mis0), 1);

    cyc = 0; base = pulses;
    drive(1'b1, 3'b111, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b111, 3'b100, 1000, 0, 0);
    drive(1'b0, 3'b111, 3'b000, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_sample_out", int'(so0), 0);
    chk("midrst_missed", int'(mis0), 0);
    chk("midrst_ready", int'(nsr0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(12);
    chk("midrst_no_pulse", pulses - base, 0);

    run_basic("after_rst");

    chk("overrun_clear", int'(ovr0), 0);
    cyc = 0; base = pulses;
    drive(1'b1, 3'b000, 3'b000, 0, 0, 0);
    drive(1'b0, 3'b000, 3'b000, 0, 0, 0);
    drive(1'b1, 3'b000, 3'b000, 0, 0, 0);
    idle(6);
    chk("overrun_pulses", pulses - base, 1);
    chk("overrun_pulse_cyc", last_pulse, 3);
    chk("overrun_sample_out", int'(so0), 0);
    chk("overrun_set", int'(ovr0), 1);
    idle(4);
    chk("overrun_sticky", int'(ovr0), 1);
    reset = 1'b1;
    #1;
    chk("overrun_reset", int'(ovr0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chord_mixer.md
# chord_mixer

Combines the three per-voice sample streams from the chord player into the single 16-bit sample the codec consumes. On each codec sample request it latches which voices are sounding, then collects one sample from each active voice. It sums them with an optional attenuation shift and saturation, and presents one registered mixed sample with a one-cycle ready pulse. It sits between the chord player's concatenated sample/ready outputs and the codec interface.

## Interface
- TIMEOUT, 64: max cycles spent collecting before mixing whatever has arrived (≥2).
- SHIFT, 0: arithmetic right shift applied to the 18-bit sum before saturation (0–2).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- generate_next_sample  in  1  codec request pulse, same signal the note players receive.
- voice_active  in  3  per-voice "note sounding" (inverse of player done flags); bit 2 = player1, bit 0 = player3.
- sample_in  in  48  {player1, player2, player3} signed 16-bit samples.
- sample_valid  in  3  per-voice new_sample_ready pulses, same bit order.
- sample_out  out  16  signed mixed sample, held until next update.
- new_sample_ready  out  1  one-cycle pulse when sample_out updates.
- missed  out  3  voices that were in mask but absent at mix time; updated with sample_out.
- overrun  out  1  sticky: request arrived while not IDLE.

## Operation
- States: IDLE, COLLECT, SUM.
- IDLE: on generate_next_sample=1, latch mask = voice_active, clear got mask and captured samples to 0, clear timer, go to COLLECT. sample_valid is ignored in IDLE, including the request cycle.
- COLLECT: for each bit i with mask[i]=1 and sample_valid[i]=1, capture sample_in slice i and set got[i]. A repeat valid on an already-captured voice overwrites the held sample with the newer one. Valids on unmasked voices are ignored.
- COLLECT completion:
  - Complete when (got | new captures this cycle) covers mask → SUM next cycle.
  - Otherwise timer increments; if timer == TIMEOUT-1 → SUM next cycle.
  - mask == 0 completes in its first COLLECT cycle.
- SUM (one cycle):
  - sum = sign-extended 18-bit addition of the three held samples; uncaptured or unmasked voices contribute 0.
  - Apply arithmetic shift right by SHIFT.
  - Saturate to [-32768, 32767].
  - Register into sample_out; missed = mask & ~got; pulse new_sample_ready; return to IDLE.
- generate_next_sample while in COLLECT or SUM: ignored (no restart), overrun set to 1 until reset.
- voice_active changes during COLLECT do not alter mask.

## Timing
- Reset (async, any state):
  - State → IDLE.
  - sample_out = 0, new_sample_ready = 0, missed = 0, overrun = 0.
  - Mask, got, held samples and timer cleared.
  - Reset mid-collection discards the partial mix; no pulse is produced.
- Request accepted at cycle 0 → COLLECT from cycle 1.
- Last required valid at cycle k (k≥1) → SUM at k+1 → sample_out/new_sample_ready visible at k+2, state IDLE at k+2.
- A request at cycle k+2 is accepted normally.
- mask == 0: output 0 with pulse at cycle 3.
- Timeout: COLLECT occupies cycles 1..TIMEOUT, SUM at TIMEOUT+1, output at TIMEOUT+2.
- new_sample_ready is exactly one cycle wide and never asserted outside the cycle after SUM.

## Test plan
- Three voices active, request at cycle 0; valids with 1000, 2000, -500 at cycles 3, 5, 5 → sample_out=2500, pulse at cycle 7, missed=000.
- Saturation, SHIFT=0: three voices at 30000 each → sample_out=32767; three voices at -30000 → -32768. Same positive stimulus with SHIFT=1 → 32767 (45000 saturated); with SHIFT=2 → 22500.
- voice_active=101, valids at cycle 2 on all three bits with player2 = 9999 → player2 ignored; sum of player1 and player3 only; output at cycle 4.
- TIMEOUT=8, mask=111, player3 never valid, others 100 and 200 → sample_out=300, missed=001, pulse at cycle 10.
- Request at cycle 0 and again at cycle 2 → single pulse; overrun=1 and stays 1; voice_active=000 request → sample_out=0 at cycle 3.
- Assert reset at cycle 3 of a collection → all outputs 0 immediately, no pulse follows; a fresh request then behaves as the first scenario.
